// File: rtl/fadd_share.sv
// Shares one pipelined fadd between NREQ requesters: round-robin issue, a LAT-deep tag
// pipeline that steers each result back, and a one-entry result buffer per requester.
module fadd_share #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 1,
    parameter int unsigned IDXW = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_x1,
    input  logic [NREQ*32-1:0]  req_x2,
    output logic [NREQ-1:0]     res_valid,
    input  logic [NREQ-1:0]     res_ready,
    output logic [NREQ*32-1:0]  res_y,
    output logic [31:0]         fadd_x1,
    output logic [31:0]         fadd_x2,
    input  logic [31:0]         fadd_y
);

    logic [LAT-1:0]             tag_vld_q, tag_vld_d;
    logic [LAT-1:0][IDXW-1:0]   tag_idx_q, tag_idx_d;
    logic [NREQ-1:0]            res_vld_q, res_vld_d;
    logic [NREQ-1:0][31:0]      res_y_q, res_y_d;
    logic [IDXW-1:0]            ptr_q, ptr_d;

    logic [NREQ-1:0]            busy;
    logic [NREQ-1:0]            elig;
    logic [NREQ-1:0][31:0]      x1_v, x2_v;
    logic [IDXW-1:0]            scan_idx;
    logic                       gnt_vld;
    logic [IDXW-1:0]            gnt_idx;
    logic                       arr_vld;
    logic [IDXW-1:0]            arr_idx;

    assign x1_v    = req_x1;
    assign x2_v    = req_x2;
    assign arr_vld = tag_vld_q[LAT-1];
    assign arr_idx = tag_idx_q[LAT-1];

    // A requester is busy from grant until its buffered result is popped.
    always_comb begin
        busy = res_vld_q;
        for (int unsigned s = 0; s < LAT; s++) begin
            if (tag_vld_q[s]) begin
                busy[tag_idx_q[s]] = 1'b1;
            end
        end
        elig = req_valid & ~busy;
    end

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = IDXW'((32'(ptr_q) + k) % NREQ);
            if (!gnt_vld && elig[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_vld && rstn) begin
            req_ready[gnt_idx] = 1'b1;
        end
        fadd_x1 = gnt_vld ? x1_v[gnt_idx] : '0;
        fadd_x2 = gnt_vld ? x2_v[gnt_idx] : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + IDXW'(1);
        end

        tag_vld_d    = tag_vld_q;
        tag_idx_d    = tag_idx_q;
        tag_vld_d[0] = gnt_vld;
        tag_idx_d[0] = gnt_idx;
        for (int unsigned s = 1; s < LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end

        // Pops and arrivals never target the same slot, so their order here is free.
        res_vld_d = res_vld_q & ~res_ready;
        res_y_d   = res_y_q;
        if (arr_vld) begin
            res_vld_d[arr_idx] = 1'b1;
            res_y_d[arr_idx]   = fadd_y;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_vld_q <= '0;
            tag_idx_q <= '0;
            res_vld_q <= '0;
            res_y_q   <= '0;
            ptr_q     <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_idx_q <= tag_idx_d;
            res_vld_q <= res_vld_d;
            res_y_q   <= res_y_d;
            ptr_q     <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && arr_vld) begin
            arrival_pop_collision: assert (!(res_vld_q[arr_idx] && res_ready[arr_idx]));
        end
    end

    assign res_valid = res_vld_q;
    assign res_y     = res_y_q;

endmodule

// File: tb/tb_fadd_share.sv
// Directed bench for fadd_share: a LAT=1 and a LAT=3 instance share stimulus,
// each fed by its own behavioural fadd pipeline.
module tb_fadd_share;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   req_valid, res_ready;
    logic [31:0]  op1 [4];
    logic [31:0]  op2 [4];
    logic [127:0] req_x1, req_x2;

    logic [3:0]   rdy1, vld1, rdy3, vld3;
    logic [127:0] y1, y3;
    logic [31:0]  fx1_1, fx2_1, fy1, fx1_3, fx2_3, fy3;
    logic [31:0]  p1_q;
    logic [31:0]  p3_q [3];

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rr;
        logic [3:0] rdy;
        logic [3:0] vld;
        logic [3:0] ym;
    } vec_t;
    vec_t        tbl [15];
    logic [31:0] yv [4];
    logic [31:0] ex1, ex2;
    logic [3:0]  s2_rdy [8];
    logic [3:0]  s2_vld [8];
    logic [3:0]  s3_pat [3];

    always #5 clk = ~clk;

    assign req_x1 = {op1[3], op1[2], op1[1], op1[0]};
    assign req_x2 = {op2[3], op2[2], op2[1], op2[0]};

    fadd_share #(.NREQ(4), .LAT(1), .IDXW(2)) u1 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(rdy1), .req_x1(req_x1), .req_x2(req_x2),
        .res_valid(vld1), .res_ready(res_ready), .res_y(y1),
        .fadd_x1(fx1_1), .fadd_x2(fx2_1), .fadd_y(fy1)
    );

    fadd_share #(.NREQ(4), .LAT(3), .IDXW(2)) u3 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(rdy3), .req_x1(req_x1), .req_x2(req_x2),
        .res_valid(vld3), .res_ready(res_ready), .res_y(y3),
        .fadd_x1(fx1_3), .fadd_x2(fx2_3), .fadd_y(fy3)
    );

    function automatic logic [31:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000, 64'h40000000_3F800000: return 32'h40400000;
            64'h3FC00000_3FC00000:                        return 32'h40400000;
            64'h3F800000_3F800000:                        return 32'h40000000;
            64'h40000000_40000000:                        return 32'h40800000;
            default:                                      return 32'h7FC00000;
        endcase
    endfunction

    always @(posedge clk) begin
        p1_q    <= fadd_ref(fx1_1, fx2_1);
        p3_q[0] <= fadd_ref(fx1_3, fx2_3);
        p3_q[1] <= p3_q[0];
        p3_q[2] <= p3_q[1];
    end
    assign fy1 = p1_q;
    assign fy3 = p3_q[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        res_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic set_rr_ops();
        op1[0] = 32'h3FC00000; op2[0] = 32'h3FC00000;
        op1[1] = 32'h3F800000; op2[1] = 32'h3F800000;
        op1[2] = 32'h40000000; op2[2] = 32'h40000000;
        op1[3] = 32'h3F800000; op2[3] = 32'h40000000;
        yv[0] = 32'h40400000; yv[1] = 32'h40000000;
        yv[2] = 32'h40800000; yv[3] = 32'h40400000;
    endtask

    initial begin
        // rv, rr, expected req_ready, expected res_valid, slots already written
        tbl[0]  = '{4'hF, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[1]  = '{4'hF, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        tbl[2]  = '{4'hF, 4'b0000, 4'b0100, 4'b0001, 4'b0001};
        tbl[3]  = '{4'hF, 4'b0000, 4'b1000, 4'b0011, 4'b0011};
        tbl[4]  = '{4'hF, 4'b0000, 4'b0000, 4'b0111, 4'b0111};
        tbl[5]  = '{4'hF, 4'b0101, 4'b0000, 4'b1111, 4'b1111};
        tbl[6]  = '{4'hF, 4'b0101, 4'b0001, 4'b1010, 4'b1111};
        tbl[7]  = '{4'hF, 4'b0101, 4'b0100, 4'b1010, 4'b1111};
        tbl[8]  = '{4'hF, 4'b0101, 4'b0000, 4'b1011, 4'b1111};
        tbl[9]  = '{4'hF, 4'b0101, 4'b0001, 4'b1110, 4'b1111};
        tbl[10] = '{4'hF, 4'b0101, 4'b0100, 4'b1010, 4'b1111};
        tbl[11] = '{4'hE, 4'b0111, 4'b0000, 4'b1011, 4'b1111};
        tbl[12] = '{4'hE, 4'b0111, 4'b0010, 4'b1100, 4'b1111};
        tbl[13] = '{4'hE, 4'b0111, 4'b0100, 4'b1000, 4'b1111};
        tbl[14] = '{4'hE, 4'b0111, 4'b0000, 4'b1010, 4'b1111};
        s2_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        s2_vld = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        s3_pat = '{4'b0001, 4'b1000, 4'b0000};

        for (int i = 0; i < 4; i++) begin
            op1[i] = '0;
            op2[i] = '0;
        end

        // Single op, both latencies
        do_reset();
        op1[0] = 32'h3F800000; op2[0] = 32'h40000000;
        req_valid = 4'b0001;
        #1;
        chk("s1 rst vld1", 32'(vld1), 32'h0);
        chk("s1 rst y1_0", y1[31:0], 32'h0);
        chk("s1 rdy1", 32'(rdy1), 32'h1);
        chk("s1 rdy3", 32'(rdy3), 32'h1);
        chk("s1 fx1", fx1_1, 32'h3F800000);
        chk("s1 fx2", fx2_1, 32'h40000000);
        tick(); #1;
        chk("s1 e1 rdy1", 32'(rdy1), 32'h0);
        chk("s1 e1 vld1", 32'(vld1), 32'h0);
        chk("s1 e1 idle fx1", fx1_1, 32'h0);
        tick(); #1;
        chk("s1 e2 vld1", 32'(vld1), 32'h1);
        chk("s1 e2 y1_0", y1[31:0], 32'h40400000);
        chk("s1 e2 rdy1", 32'(rdy1), 32'h0);
        chk("s1 e2 vld3", 32'(vld3), 32'h0);
        tick(); #1;
        chk("s1 e3 vld3", 32'(vld3), 32'h0);
        tick(); #1;
        chk("s1 e4 vld3", 32'(vld3), 32'h1);
        chk("s1 e4 y3_0", y3[31:0], 32'h40400000);
        chk("s1 e4 rdy1", 32'(rdy1), 32'h0);
        res_ready = 4'b0001;
        #1;
        chk("s1 pop cycle rdy1", 32'(rdy1), 32'h0);
        tick();
        res_ready = 4'b0000;
        #1;
        chk("s1 e5 vld1", 32'(vld1), 32'h0);
        chk("s1 e5 vld3", 32'(vld3), 32'h0);
        chk("s1 e5 rdy1", 32'(rdy1), 32'h1);
        chk("s1 e5 rdy3", 32'(rdy3), 32'h1);
        chk("s1 e5 y1_0 held", y1[31:0], 32'h40400000);

        // Round-robin and held-result blocking, LAT=1, table driven
        do_reset();
        set_rr_ops();
        for (int k = 0; k < 15; k++) begin
            req_valid = tbl[k].rv;
            res_ready = tbl[k].rr;
            #1;
            ex1 = '0;
            ex2 = '0;
            for (int i = 0; i < 4; i++) begin
                if (tbl[k].rdy[i]) begin
                    ex1 = op1[i];
                    ex2 = op2[i];
                end
            end
            chk($sformatf("v%0d rdy", k), 32'(rdy1), 32'(tbl[k].rdy));
            chk($sformatf("v%0d vld", k), 32'(vld1), 32'(tbl[k].vld));
            chk($sformatf("v%0d fx1", k), fx1_1, ex1);
            chk($sformatf("v%0d fx2", k), fx2_1, ex2);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("v%0d y%0d", k, i), y1[32*i +: 32], tbl[k].ym[i] ? yv[i] : 32'h0);
            end
            tick();
        end

        // Round-robin, LAT=3
        do_reset();
        set_rr_ops();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("s2 c%0d rdy3", k), 32'(rdy3), 32'(s2_rdy[k]));
            chk($sformatf("s2 c%0d vld3", k), 32'(vld3), 32'(s2_vld[k]));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s2 y3_%0d", i), y3[32*i +: 32], yv[i]);
        end

        // Pointer wrap: r0 issued last, so r2 wins when both free up together
        do_reset();
        set_rr_ops();
        req_valid = 4'b0100;
        #1; chk("s3 c1 rdy", 32'(rdy1), 32'b0100);
        tick();
        req_valid = 4'b0101;
        #1; chk("s3 c2 rdy", 32'(rdy1), 32'b0001);
        tick();
        #1; chk("s3 c3 vld", 32'(vld1), 32'b0100);
        tick();
        res_ready = 4'b0101;
        #1; chk("s3 c4 vld", 32'(vld1), 32'b0101);
        tick();
        res_ready = 4'b0000;
        #1; chk("s3 c5 rdy", 32'(rdy1), 32'b0100);
        tick();
        #1; chk("s3 c6 rdy", 32'(rdy1), 32'b0001);

        // Requesters 0 and 3 alternate with immediate pops
        do_reset();
        set_rr_ops();
        req_valid = 4'b1001;
        res_ready = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("s3 alt c%0d rdy", k), 32'(rdy1), 32'(s3_pat[k % 3]));
            tick();
        end
        chk("s3 alt y0", y1[31:0], 32'h40400000);
        chk("s3 alt y3", y1[127:96], 32'h40400000);

        // Reset while an op for requester 2 is in flight
        do_reset();
        set_rr_ops();
        req_valid = 4'b0100;
        #1; chk("s4 rdy", 32'(rdy1), 32'b0100);
        tick();
        rstn = 1'b0;
        #1;
        chk("s4 in rst rdy1", 32'(rdy1), 32'h0);
        chk("s4 in rst rdy3", 32'(rdy3), 32'h0);
        repeat (2) tick();
        rstn = 1'b1;
        req_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("s4 c%0d vld1", k), 32'(vld1), 32'h0);
            chk($sformatf("s4 c%0d vld3", k), 32'(vld3), 32'h0);
            chk($sformatf("s4 c%0d y1_2", k), y1[95:64], 32'h0);
            tick();
        end
        req_valid = 4'b1001;
        #1;
        chk("s4 ptr rdy1", 32'(rdy1), 32'b0001);
        chk("s4 ptr rdy3", 32'(rdy3), 32'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fadd_share.md
Name: fadd_share

Overview:
- Shares one pipelined fadd datapath between NREQ independent requesters.
- Each requester has a valid/ready operand port and a one-entry result buffer with its own valid/ready handshake.
- A round-robin arbiter issues at most one operation per cycle. A tag pipeline of depth LAT routes each fadd result back to the requester that issued it.
- Sits between FPU-using units (for example the issue stage or a vector sequencer) and a single fadd instance.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- LAT, 1: fadd latency in clock edges from operand capture to a valid y.
- IDXW, 2: tag index width, equal to clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  operand request per requester.
- req_ready  out  NREQ  grant; a request is accepted when req_valid[i] and req_ready[i] are both high at a rising edge.
- req_x1  in  NREQ*32  packed operand 1; slice i is bits [32i+31:32i].
- req_x2  in  NREQ*32  packed operand 2, same packing as req_x1.
- res_valid  out  NREQ  result buffer i is full.
- res_ready  in  NREQ  requester i consumes its result.
- res_y  out  NREQ*32  packed result buffers.
- fadd_x1  out  32  operand 1 to the shared fadd.
- fadd_x2  out  32  operand 2 to the shared fadd.
- fadd_y  in  32  result from the shared fadd.

Behaviour:
- Reset, asynchronous on rstn low:
  - res_valid = 0 and all res_y = 0.
  - Tag pipeline emptied; in-flight operations are discarded and never delivered.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - req_ready = 0 while rstn is low.
- Busy flags:
  - busy[i] = an op for i is in the tag pipeline, OR res_valid[i] is high.
  - Each requester has at most one outstanding op, so a result slot is always free on arrival and no fadd backpressure is needed.
- Eligibility and grant:
  - eligible[i] = req_valid[i] and not busy[i].
  - Grant goes to the first eligible index scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready is a one-hot or zero vector, combinational from req_valid and state.
  - Requesters must not make req_valid depend on req_ready.
- Pointer update: on an accepted request from index g, ptr becomes (g+1) mod NREQ. With no grant, ptr holds.
- Operand drive:
  - fadd_x1/fadd_x2 = the granted requester's slices, combinationally.
  - With no grant, fadd_x1/fadd_x2 = 0.
- Latency:
  - An op accepted at edge t has its tag {valid, idx} shifted through LAT registers.
  - fadd_y for that op is valid after edge t+LAT-1 and is captured into res_y[idx] at edge t+LAT; res_valid[idx] rises then.
  - With LAT=1: accept at edge t, res_valid high after edge t+1.
  - Issue-to-result is LAT edges; sustained throughput is 1 op/cycle across different requesters.
- Result consumption:
  - res_valid[i] && res_ready[i] at an edge clears res_valid[i]. res_y[i] holds its last value.
  - Busy is evaluated from registered state, so requester i cannot issue in the same cycle it pops. Its next issue is at the earliest the following edge, which gives a per-requester issue interval of LAT+2 edges with res_ready held high.
- Simultaneous events:
  - A tag arrival for i and a pop of i in the same edge cannot occur, because busy prevents it. The implementation asserts this in simulation.
  - Captures and pops for different indices in the same edge are independent.
- res_ready[i] asserted while res_valid[i] is low has no effect.
- Idle: with no eligible requester the fadd sees zero operands and no tag is inserted. The fadd's output for these idle slots is ignored.

Test Plan:
- Single op: reset, requester 0 sends 0x3F800000 + 0x40000000 (1.0+2.0) at edge 1 → req_ready[0]=1 at edge 1; res_valid[0] high after edge 2 with res_y[0]=0x40400000; requester 0 not granted again until after the pop edge.
- Round-robin: all 4 requesters hold req_valid from reset → grants in order 0,1,2,3 on consecutive edges; each result captured LAT edges after its grant into the correct slot (operand sets 1.5+1.5=0x40400000, 1.0+1.0=0x40000000, 2.0+2.0=0x40800000, 1.0+2.0=0x40400000).
- Held result blocks issue: requester 1 keeps res_ready=0 with res_valid[1]=1 and req_valid[1]=1 → req_ready[1] stays 0 while requesters 0 and 2 continue to be served; releasing res_ready gives requester 1 a grant the edge after the pop.
- Pointer fairness: requesters 0 and 3 are continuously valid with immediate res_ready → grants alternate and neither waits more than one grant slot.
- Reset mid-flight: assert rstn low the cycle after a grant to requester 2 → res_valid stays 0 after reset release, ptr=0, and no stale result appears.
- LAT=3 build: repeat scenarios 1 and 2 → result capture occurs 3 edges after grant and tags are routed correctly.
